// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control slice.
// Holds the state encodings, opcode/funct constants, ALUOp codes and the
// datapath select codes (PCSource, ALUSrcB, RegDst, MemtoReg).
package mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd15
  } state_t;

  // Opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Funct (Instruction[5:0])
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALUOp codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // RegDst selects
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that own the shared memory port and are subject to the wait timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state counter for the memory handshake.
// Ports:
//   CLK     in  clock, rising edge
//   RESET   in  asynchronous active-low reset
//   clr     in  synchronous clear (has priority over inc)
//   inc     in  count one more MEM_READY-low cycle
//   expired out counter has reached MEM_TIMEOUT
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared memory port and
// drives the datapath muxes and write enables. A memory state that sees
// MEM_READY low for too long, or an unknown opcode, parks the FSM in a sticky
// HALT state that only RESET leaves.
// Ports:
//   CLK, RESET          clock / asynchronous active-low reset
//   opcode, funct       instruction fields from the IR
//   MEM_READY           memory completes the current request this cycle
//   MEM_REQ, MemRead, MemWrite, IorD     memory port control
//   IRWrite, PCWrite, PCWriteCond, BranchNE, PCSource   IR/PC control
//   ALUSrcA, ALUSrcB, ALUOp              ALU operand/operation selects
//   RegDst, MemtoReg, RegWrite           register file control
//   HALT                sticky fault flag
//   STATE               current state encoding (debug)
// Handshake: a request is outstanding whenever MEM_REQ=1; it completes in the
// cycle where MEM_REQ=1 and MEM_READY=1. MEM_READY with MEM_REQ=0 is ignored.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter int STATE_W     = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               MEM_READY,
  output logic               MEM_REQ,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNE,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               HALT,
  output logic [STATE_W-1:0] STATE
);

  state_t state_q, state_d;
  logic   in_mem, expired, timeout;
  logic   ir_write_c, pc_write_c, mem_write_c, reg_write_c;

  // Counter is held at zero outside memory states, so every entry starts fresh.
  assign in_mem  = is_mem_state(state_q);
  assign timeout = in_mem && !MEM_READY && expired;

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (!in_mem || MEM_READY),
    .inc    (in_mem && !MEM_READY),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    MEM_REQ     = 1'b0;
    MemRead     = 1'b0;
    mem_write_c = 1'b0;
    IorD        = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALU_ADD;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    reg_write_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        MEM_REQ = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MEM_READY) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target PC+(imm<<2) is precomputed into ALUOut here.
        ALUSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:                           state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_EXEC_I;
          OP_J:                               state_d = S_JUMP;
          OP_JAL:                             state_d = S_JAL;
          default:                            state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegDst      = REGDST_RD;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_ANDI: ALUOp = ALU_AND;
          OP_ORI:  ALUOp = ALU_OR;
          OP_SLTI: ALUOp = ALU_SLT;
          default: ALUOp = ALU_ADD;
        endcase
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MEM_REQ = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MEM_READY) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        MEM_REQ     = 1'b1;
        mem_write_c = 1'b1;
        IorD        = 1'b1;
        if (MEM_READY) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        MemtoReg    = M2R_MDR;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        BranchNE    = (opcode == OP_BNE);
        PCSource    = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        PCSource   = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value.
        pc_write_c  = 1'b1;
        PCSource    = PCSRC_JUMP;
        RegDst      = REGDST_R31;
        MemtoReg    = M2R_PC;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JR: begin
        pc_write_c = 1'b1;
        PCSource   = PCSRC_RS;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (timeout) state_d = S_HALT;
  end

  // Architectural write enables fall with RESET without waiting for a clock,
  // so an aborted instruction can never commit a partial write.
  assign IRWrite  = ir_write_c  & RESET;
  assign PCWrite  = pc_write_c  & RESET;
  assign MemWrite = mem_write_c & RESET;
  assign RegWrite = reg_write_c & RESET;

  assign HALT  = (state_q == S_HALT);
  assign STATE = STATE_W'(state_q);

endmodule
